// File: rtl/vending_ctrl_if.sv
// Front-end / dispenser bundle for vending_ctrl.
// The master side (keypad, coin acceptor, hopper) drives strobes; the slave is the controller.
interface vending_ctrl_if #(
  parameter int unsigned MONEY_W = 8,
  parameter int unsigned N_ITEMS = 4,
  parameter int unsigned SEL_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) ();
  logic               coin_valid;
  logic [MONEY_W-1:0] coin_value;
  logic               sel_valid;
  logic [SEL_W-1:0]   sel;
  logic               cancel;
  logic               restock;
  logic               change_ready;
  logic [MONEY_W-1:0] credit;
  logic [N_ITEMS-1:0] affordable;
  logic               coin_reject;
  logic               vend_valid;
  logic [SEL_W-1:0]   vend_item;
  logic               change_valid;
  logic [MONEY_W-1:0] change_coin;
  logic               err;
  logic [1:0]         err_code;
  logic               busy;

  modport master (
    output coin_valid, coin_value, sel_valid, sel, cancel, restock, change_ready,
    input  credit, affordable, coin_reject, vend_valid, vend_item, change_valid, change_coin,
           err, err_code, busy
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel, cancel, restock, change_ready,
    output credit, affordable, coin_reject, vend_valid, vend_item, change_valid, change_coin,
           err, err_code, busy
  );
endinterface

// File: rtl/vending_ctrl.sv
// N-product vending controller: credit accumulation, priced selection with stock tracking,
// cancel/refund and coin-by-coin change payout. All outputs registered.
module vending_ctrl #(
  parameter int unsigned MONEY_W    = 8,
  parameter int unsigned N_ITEMS    = 4,
  parameter int unsigned PRICE_BASE = 10,
  parameter int unsigned PRICE_STEP = 5,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 3,
  parameter int unsigned MAX_CREDIT = 99
) (
  input logic           clk_i,
  input logic           reset_i,
  vending_ctrl_if.slave bus_io
);

  localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

  typedef enum logic [1:0] {StIdle, StCredit, StVend, StChange} state_e;

  function automatic logic [MONEY_W-1:0] price(input int unsigned idx);
    return MONEY_W'(PRICE_BASE + idx * PRICE_STEP);
  endfunction

  // Greedy payout: biggest denomination that still fits in the remaining credit.
  function automatic logic [MONEY_W-1:0] largest_coin(input logic [MONEY_W-1:0] amt);
    if (amt >= MONEY_W'(50))      return MONEY_W'(50);
    else if (amt >= MONEY_W'(10)) return MONEY_W'(10);
    else if (amt >= MONEY_W'(5))  return MONEY_W'(5);
    else if (amt != '0)           return MONEY_W'(1);
    else                          return '0;
  endfunction

  state_e             state_q, state_d;
  logic [MONEY_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0] stock_q [N_ITEMS];
  logic [STOCK_W-1:0] stock_d [N_ITEMS];
  logic [N_ITEMS-1:0] affordable_q, affordable_d;
  logic               coin_reject_q, coin_reject_d;
  logic               vend_valid_q, vend_valid_d;
  logic [SEL_W-1:0]   vend_item_q, vend_item_d;
  logic               change_valid_q, change_valid_d;
  logic [MONEY_W-1:0] change_coin_q, change_coin_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               busy_q, busy_d;

  logic [MONEY_W:0]   coin_sum;
  logic               denom_ok;
  logic               coin_ok;
  logic               sel_bad;
  logic [MONEY_W-1:0] sel_price;

  // One spare bit so credit + coin cannot wrap before the ceiling test.
  assign coin_sum  = {1'b0, credit_q} + {1'b0, bus_io.coin_value};
  assign denom_ok  = (bus_io.coin_value == MONEY_W'(1))  || (bus_io.coin_value == MONEY_W'(5)) ||
                     (bus_io.coin_value == MONEY_W'(10)) || (bus_io.coin_value == MONEY_W'(50));
  assign coin_ok   = denom_ok && (coin_sum <= (MONEY_W + 1)'(MAX_CREDIT));
  assign sel_bad   = 32'(bus_io.sel) >= N_ITEMS;
  assign sel_price = price(32'(bus_io.sel));

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    stock_d        = stock_q;
    coin_reject_d  = 1'b0;
    vend_valid_d   = 1'b0;
    vend_item_d    = vend_item_q;
    change_valid_d = 1'b0;
    change_coin_d  = '0;
    err_d          = 1'b0;
    err_code_d     = err_code_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum[MONEY_W-1:0];
            state_d  = StCredit;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      StCredit: begin
        if (bus_io.cancel) begin
          coin_reject_d  = bus_io.coin_valid;
          state_d        = StChange;
          change_valid_d = 1'b1;
          change_coin_d  = largest_coin(credit_q);
        end else if (bus_io.sel_valid) begin
          coin_reject_d = bus_io.coin_valid;
          if (sel_bad) begin
            err_d      = 1'b1;
            err_code_d = 2'd3;
          end else if (stock_q[bus_io.sel] == '0) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end else if (credit_q < sel_price) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end else begin
            credit_d            = credit_q - sel_price;
            stock_d[bus_io.sel] = stock_q[bus_io.sel] - STOCK_W'(1);
            vend_valid_d        = 1'b1;
            vend_item_d         = bus_io.sel;
            state_d             = StVend;
          end
        end else if (bus_io.coin_valid) begin
          if (coin_ok) credit_d = coin_sum[MONEY_W-1:0];
          else         coin_reject_d = 1'b1;
        end
      end
      StVend: begin
        coin_reject_d = bus_io.coin_valid;
        if (credit_q != '0) begin
          state_d        = StChange;
          change_valid_d = 1'b1;
          change_coin_d  = largest_coin(credit_q);
        end else begin
          state_d = StIdle;
        end
      end
      StChange: begin
        coin_reject_d = bus_io.coin_valid;
        if (bus_io.change_ready) begin
          credit_d = credit_q - change_coin_q;
          if (credit_d == '0) begin
            state_d = StIdle;
          end else begin
            change_valid_d = 1'b1;
            change_coin_d  = largest_coin(credit_d);
          end
        end else begin
          change_valid_d = 1'b1;
          change_coin_d  = change_coin_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // Restock wins over a same-edge vend decrement.
    if (bus_io.restock) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
    end

    busy_d = (state_d == StVend) || (state_d == StChange);
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      affordable_d[i] = (credit_d >= price(i)) && (stock_d[i] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      for (int unsigned i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      affordable_q   <= '0;
      coin_reject_q  <= 1'b0;
      vend_valid_q   <= 1'b0;
      vend_item_q    <= '0;
      change_valid_q <= 1'b0;
      change_coin_q  <= '0;
      err_q          <= 1'b0;
      err_code_q     <= 2'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      stock_q        <= stock_d;
      affordable_q   <= affordable_d;
      coin_reject_q  <= coin_reject_d;
      vend_valid_q   <= vend_valid_d;
      vend_item_q    <= vend_item_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      busy_q         <= busy_d;
    end
  end

  assign bus_io.credit       = credit_q;
  assign bus_io.affordable   = affordable_q;
  assign bus_io.coin_reject  = coin_reject_q;
  assign bus_io.vend_valid   = vend_valid_q;
  assign bus_io.vend_item    = vend_item_q;
  assign bus_io.change_valid = change_valid_q;
  assign bus_io.change_coin  = change_coin_q;
  assign bus_io.err          = err_q;
  assign bus_io.err_code     = err_code_q;
  assign bus_io.busy         = busy_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Scoreboard bench for vending_ctrl: a transaction-level model queues expected events,
// a negedge monitor pops and compares them as the controller presents outputs.
module tb_vending_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  vending_ctrl_if #(.MONEY_W(8), .N_ITEMS(N)) bus ();

  vending_ctrl #(
    .MONEY_W(8), .N_ITEMS(N), .PRICE_BASE(10), .PRICE_STEP(5),
    .STOCK_W(4), .STOCK_INIT(3), .MAX_CREDIT(99)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int credit_m;
  int stock_m [N];
  int q_vend [$];
  int q_err [$];
  int q_change [$];
  int exp_rej;
  int ready_mode; // 0 low, 1 high, 2 random

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int price_m(input int i);
    return 10 + 5 * i;
  endfunction

  function automatic void pay(input int amt);
    int c;
    while (amt > 0) begin
      c = (amt >= 50) ? 50 : (amt >= 10) ? 10 : (amt >= 5) ? 5 : 1;
      q_change.push_back(c);
      amt -= c;
    end
  endfunction

  function automatic int aff_m();
    int a = 0;
    for (int i = 0; i < N; i++)
      if (credit_m >= price_m(i) && stock_m[i] != 0) a |= (1 << i);
    return a;
  endfunction

  function automatic void model_reset();
    credit_m = 0;
    for (int i = 0; i < N; i++) stock_m[i] = 3;
    q_vend.delete();
    q_err.delete();
    q_change.delete();
    exp_rej = 0;
  endfunction

  function automatic void model_coin(input int v);
    if ((v == 1 || v == 5 || v == 10 || v == 50) && credit_m + v <= 99) credit_m += v;
    else exp_rej++;
  endfunction

  function automatic void model_op(input bit cv, input int val, input bit sv, input int s,
                                   input bit cn, input bit rs);
    if (credit_m > 0) begin
      if (cn) begin
        if (cv) exp_rej++;
        pay(credit_m);
        credit_m = 0;
      end else if (sv) begin
        if (cv) exp_rej++;
        if (s >= N) q_err.push_back(3);
        else if (stock_m[s] == 0) q_err.push_back(2);
        else if (credit_m < price_m(s)) q_err.push_back(1);
        else begin
          q_vend.push_back(s);
          stock_m[s]--;
          pay(credit_m - price_m(s));
          credit_m = 0;
        end
      end else if (cv) model_coin(val);
    end else if (cv) model_coin(val);
    if (rs) for (int i = 0; i < N; i++) stock_m[i] = 3;
  endfunction

  // Monitor: every presented output event is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.coin_reject) begin
          check("coin_reject_expected", 1, (exp_rej > 0) ? 1 : 0);
          if (exp_rej > 0) exp_rej--;
        end
        if (bus.err) begin
          if (q_err.size() == 0) check("err_unexpected", 1, 0);
          else check("err_code", int'(bus.err_code), q_err.pop_front());
        end
        if (bus.vend_valid) begin
          if (q_vend.size() == 0) check("vend_unexpected", 1, 0);
          else check("vend_item", int'(bus.vend_item), q_vend.pop_front());
        end
        if (bus.change_valid) begin
          if (q_change.size() == 0) check("change_unexpected", int'(bus.change_coin), 0);
          else if (bus.change_ready) check("change_coin", int'(bus.change_coin),
                                           q_change.pop_front());
          else check("change_coin_stalled", int'(bus.change_coin), q_change[0]);
        end
      end
    end
  end

  initial begin
    change_ready_drv: forever begin
      @(posedge clk);
      #1;
      bus.change_ready = (ready_mode == 1) ? 1'b1 :
                         (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic drive_op(input bit cv, input int val, input bit sv, input int s,
                          input bit cn, input bit rs);
    model_op(cv, val, sv, s, cn, rs);
    @(posedge clk);
    #1;
    bus.coin_valid = cv;
    bus.coin_value = 8'(val);
    bus.sel_valid  = sv;
    bus.sel        = 2'(s);
    bus.cancel     = cn;
    bus.restock    = rs;
    @(posedge clk);
    #1;
    bus.coin_valid = 1'b0;
    bus.sel_valid  = 1'b0;
    bus.cancel     = 1'b0;
    bus.restock    = 1'b0;
  endtask

  task automatic wait_idle(output int nvalid);
    int n = 0;
    nvalid = 0;
    @(negedge clk);
    while ((bus.busy || bus.change_valid) && n < 300) begin
      if (bus.change_valid) nvalid++;
      n++;
      @(negedge clk);
    end
    if (n >= 300) check("idle_within_budget", 0, 1);
  endtask

  task automatic check_state();
    check("credit", int'(bus.credit), credit_m);
    check("affordable", int'(bus.affordable), aff_m());
  endtask

  task automatic do_op(input bit cv, input int val, input bit sv, input int s,
                       input bit cn, input bit rs, output int nvalid);
    drive_op(cv, val, sv, s, cn, rs);
    wait_idle(nvalid);
    check_state();
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    check("rst_credit", int'(bus.credit), 0);
    check("rst_affordable", int'(bus.affordable), 0);
    check("rst_flags", int'({bus.coin_reject, bus.vend_valid, bus.change_valid, bus.err,
                             bus.busy}), 0);
    check("rst_vend_item", int'(bus.vend_item), 0);
    check("rst_change_coin", int'(bus.change_coin), 0);
    check("rst_err_code", int'(bus.err_code), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int nv;
  int r;
  int coin_tab [10] = '{1, 5, 10, 50, 0, 2, 7, 20, 25, 100};

  initial begin
    reset = 1'b1;
    ready_mode = 1;
    bus.coin_valid = 1'b0;
    bus.coin_value = '0;
    bus.sel_valid = 1'b0;
    bus.sel = '0;
    bus.cancel = 1'b0;
    bus.restock = 1'b0;
    bus.change_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    reset_dut();

    // Coins 10,5,5 then an illegal 7.
    do_op(1, 10, 0, 0, 0, 0, nv);
    do_op(1, 5, 0, 0, 0, 0, nv);
    do_op(1, 5, 0, 0, 0, 0, nv);
    check("credit_20", int'(bus.credit), 20);
    check("affordable_20", int'(bus.affordable), 4'b0111);
    do_op(1, 7, 0, 0, 0, 0, nv);
    check("credit_after_bad_coin", int'(bus.credit), 20);

    // Buy item 1 for 15, one 5 coin back.
    do_op(0, 0, 1, 1, 0, 0, nv);
    check("vend1_change_cycles", nv, 1);

    // Fill to 99, overflow coin, refund on consecutive cycles.
    do_op(1, 50, 0, 0, 0, 0, nv);
    repeat (4) do_op(1, 10, 0, 0, 0, 0, nv);
    do_op(1, 5, 0, 0, 0, 0, nv);
    repeat (4) do_op(1, 1, 0, 0, 0, 0, nv);
    check("credit_99", int'(bus.credit), 99);
    do_op(1, 1, 0, 0, 0, 0, nv);
    do_op(0, 0, 0, 0, 1, 0, nv);
    check("refund_99_cycles", nv, 10);

    // Sell out item 3, then restock.
    repeat (3) begin
      do_op(1, 50, 0, 0, 0, 0, nv);
      do_op(0, 0, 1, 3, 0, 0, nv);
    end
    do_op(1, 50, 0, 0, 0, 0, nv);
    do_op(0, 0, 1, 3, 0, 0, nv);
    check("soldout_err_code", int'(bus.err_code), 2);
    do_op(0, 0, 0, 0, 0, 1, nv);
    do_op(0, 0, 1, 3, 0, 0, nv);

    // Insufficient credit, then all strobes in one cycle.
    do_op(1, 10, 0, 0, 0, 0, nv);
    do_op(0, 0, 1, 2, 0, 0, nv);
    check("insufficient_err_code", int'(bus.err_code), 1);
    do_op(1, 5, 1, 0, 1, 0, nv);

    // Stalled hopper, then reset in the middle of payout.
    do_op(1, 50, 0, 0, 0, 0, nv);
    do_op(1, 10, 0, 0, 0, 0, nv);
    do_op(1, 5, 0, 0, 0, 0, nv);
    do_op(1, 1, 0, 0, 0, 0, nv);
    ready_mode = 0;
    drive_op(0, 0, 0, 0, 1, 0);
    repeat (5) @(negedge clk);
    ready_mode = 1;
    repeat (2) @(posedge clk);
    ready_mode = 0;
    repeat (2) @(negedge clk);
    check("still_paying", int'(bus.change_valid), 1);
    reset_dut();
    repeat (3) @(negedge clk);
    check("no_coin_after_reset", int'(bus.change_valid), 0);
    check_state();

    // Randomized traffic with a random hopper.
    ready_mode = 2;
    repeat (250) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      do_op(1, coin_tab[$urandom_range(0, 9)], 0, 0, 0, 0, nv);
      else if (r <= 6) do_op(0, 0, 1, $urandom_range(0, N - 1), 0, 0, nv);
      else if (r == 7) do_op(0, 0, 0, 0, 1, 0, nv);
      else if (r == 8) do_op(0, 0, 0, 0, 0, 1, nv);
      else do_op(1'($urandom_range(0, 1)), coin_tab[$urandom_range(0, 9)],
                 1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nv);
    end

    repeat (2) @(negedge clk);
    check("pending_vend", q_vend.size(), 0);
    check("pending_err", q_err.size(), 0);
    check("pending_change", q_change.size(), 0);
    check("pending_reject", exp_rej, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vending_ctrl.md
# vending_ctrl

Parametrised, fully synchronous vending-machine controller: next generation of the team's single-product-set vending FSM, generalised to N products with arithmetic price ladder, per-product stock counters, credit ceiling, cancel, and coin-by-coin change payout over a ready/valid handshake. It sits between the coin acceptor / keypad front end and the dispenser / change hopper drivers. All outputs are registered.

## Interface
- MONEY_W, 8, width of credit and coin values
- N_ITEMS, 4, number of products (≥1); SEL_W = max(1, clog2(N_ITEMS))
- PRICE_BASE, 10, price of item 0
- PRICE_STEP, 5, price increment per item index (price[i] = PRICE_BASE + i*PRICE_STEP)
- STOCK_W, 4, width of each stock counter
- STOCK_INIT, 3, stock loaded at reset and on restock
- MAX_CREDIT, 99, credit ceiling (must be < 2^MONEY_W)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- coin_valid  in  1  one coin presented this cycle
- coin_value  in  MONEY_W  coin denomination
- sel_valid  in  1  product selection strobe
- sel  in  SEL_W  product index, 0-based
- cancel  in  1  refund request
- restock  in  1  reload all stock counters to STOCK_INIT
- change_ready  in  1  hopper accepts presented change coin
- credit  out  MONEY_W  current credit
- affordable  out  N_ITEMS  bit i = credit ≥ price[i] and stock[i] ≠ 0
- coin_reject  out  1  one-cycle pulse: coin returned
- vend_valid  out  1  one-cycle pulse: dispense vend_item
- vend_item  out  SEL_W  item being dispensed (held until next vend)
- change_valid  out  1  change coin presented
- change_coin  out  MONEY_W  denomination presented (50/10/5/1)
- err  out  1  one-cycle pulse: selection refused
- err_code  out  2  1 = insufficient credit, 2 = sold out, 3 = bad index; held until next err
- busy  out  1  high in VEND or CHANGE

## Operation
- States: IDLE (credit 0), CREDIT, VEND, CHANGE.
- Accepted denominations: 1, 5, 10, 50. Any other value, or credit+coin > MAX_CREDIT, or coin in VEND/CHANGE → coin_reject, credit unchanged.
- IDLE/CREDIT: accepted coin adds to credit; IDLE→CREDIT when credit becomes nonzero.
- Priority in CREDIT when strobes coincide: cancel > sel_valid > coin_valid; lower-priority coin in the same cycle is rejected.
- Selection (CREDIT only; ignored in IDLE): sel ≥ N_ITEMS → err code 3; stock[sel]=0 → code 2; credit < price → code 1. Error leaves state and credit unchanged.
- Valid selection → VEND: credit −= price, stock[sel] −= 1, vend_valid=1, vend_item=sel. Next cycle → CHANGE if credit>0, else IDLE.
- cancel in CREDIT → CHANGE; in IDLE ignored.
- CHANGE: change_coin = largest of 50/10/5/1 ≤ credit; change_valid held high, change_coin stable until change_ready. On handshake credit −= change_coin; at credit 0 → IDLE, change_valid drops the following cycle.
- restock: any state, reloads all counters; takes effect same edge as a vend, vend decrement ignored.
- Price/credit arithmetic in MONEY_W bits; credit never underflows or exceeds MAX_CREDIT.

## Timing
- Reset values: state IDLE, credit 0, all stock = STOCK_INIT, affordable 0, coin_reject 0, vend_valid 0, vend_item 0, change_valid 0, change_coin 0, err 0, err_code 0, busy 0.
- Reset mid-CHANGE or mid-VEND abandons credit immediately; no further change coins.
- Coin → credit/coin_reject update: 1 cycle. Selection → vend_valid or err: 1 cycle. affordable tracks credit/stock with same latency as credit.
- Change payout: max one coin per cycle when change_ready held high; first coin valid the cycle after entering CHANGE.

## Test plan
- Reset, insert 10,5,5 → credit 20, affordable 0b0111 (default params); coin 7 → coin_reject, credit 20.
- Credit 20, sel 1 (price 15) → vend_valid, vend_item 1, credit 5, one change coin 5, return to IDLE.
- Credit 99 after 50+10×4+5+1×4; coin 1 → reject; cancel with change_ready tied high → coins 50,10,10,10,10,5,1,1,1,1 on consecutive cycles.
- Item 3 vended 3 times; 4th select → err, err_code 2; restock → select succeeds.
- Credit 10, sel 2 → err code 1; sel_valid, cancel and coin same cycle → refund starts, coin_reject.
- change_ready low 5 cycles in CHANGE → change_valid/change_coin stable; reset asserted mid-payout → all outputs to reset values next cycle.
